// File: rtl/sc_goal_tracker.sv
// Goal tracker: latches (x,y) targets, tracks saturated position error and declares arrival
// after SETTLE_SAMPLES consecutive in-tolerance samples. Optional SC_GOAL_TRACKER_PREEMPT_EN lets TRACK/SETTLE accept goals.
module sc_goal_tracker #(
  parameter int                 N_WIDTH        = 17,
  parameter logic [N_WIDTH-1:0] TOL            = 17'd50,
  parameter int                 SETTLE_SAMPLES = 8
) (
  input  logic               SC_GOAL_TRACKER_CLOCK_50,
  input  logic               SC_GOAL_TRACKER_RESET_InHigh,
  input  logic               SC_GOAL_TRACKER_GOAL_VALID_In,
  output logic               SC_GOAL_TRACKER_GOAL_READY_Out,
  input  logic [N_WIDTH-1:0] SC_GOAL_TRACKER_GOALX_InBus,
  input  logic [N_WIDTH-1:0] SC_GOAL_TRACKER_GOALY_InBus,
  input  logic               SC_GOAL_TRACKER_POS_VALID_In,
  input  logic [N_WIDTH-1:0] SC_GOAL_TRACKER_POSX_InBus,
  input  logic [N_WIDTH-1:0] SC_GOAL_TRACKER_POSY_InBus,
  input  logic               SC_GOAL_TRACKER_ABORT_InLow,
  output logic [N_WIDTH-1:0] SC_GOAL_TRACKER_ERRORX_OutBus,
  output logic [N_WIDTH-1:0] SC_GOAL_TRACKER_ERRORY_OutBus,
  output logic               SC_GOAL_TRACKER_NEWSIGNAL_OutLow,
  output logic               SC_GOAL_TRACKER_FLAGGOAL_OutLow,
  output logic [1:0]         SC_GOAL_TRACKER_STATE_OutBus
);
  localparam int         W        = N_WIDTH;
  localparam logic [7:0] SETTLE_N = 8'(SETTLE_SAMPLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TRACK   = 2'd1,
    S_SETTLE  = 2'd2,
    S_REACHED = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] goalx_q, goalx_d, goaly_q, goaly_d;
  logic [W-1:0] errx_q, errx_d, erry_q, erry_d;
  logic [7:0]   cnt_q, cnt_d, cnt_inc;
  logic         new_n_q, new_n_d, flag_n_q, flag_n_d;

  logic         clk, rst, abort_n, ready, accept, sample, in_tol;
  logic [W-1:0] goalx_src, goaly_src;
  logic [W:0]   diffx, diffy;

  assign clk     = SC_GOAL_TRACKER_CLOCK_50;
  assign rst     = SC_GOAL_TRACKER_RESET_InHigh;
  assign abort_n = SC_GOAL_TRACKER_ABORT_InLow;

  // Clamp an N+1-bit difference into the N-bit two's complement range.
  function automatic logic [W-1:0] sat(input logic [W:0] d);
    if (d[W] != d[W-1]) sat = d[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else                sat = d[W-1:0];
  endfunction

  function automatic logic [W:0] mag(input logic [W:0] d);
    mag = d[W] ? (~d + 1'b1) : d;
  endfunction

  // READY depends only on the state register and ABORT, never on GOAL_VALID.
  always_comb begin
`ifdef SC_GOAL_TRACKER_PREEMPT_EN
    ready = abort_n;
`else
    ready = abort_n & ((state_q == S_IDLE) | (state_q == S_REACHED));
`endif
  end

  assign accept    = SC_GOAL_TRACKER_GOAL_VALID_In & ready;
  assign sample    = SC_GOAL_TRACKER_POS_VALID_In & (state_q != S_IDLE);
  assign goalx_src = accept ? SC_GOAL_TRACKER_GOALX_InBus : goalx_q;
  assign goaly_src = accept ? SC_GOAL_TRACKER_GOALY_InBus : goaly_q;
  assign diffx     = {goalx_src[W-1], goalx_src} - {SC_GOAL_TRACKER_POSX_InBus[W-1], SC_GOAL_TRACKER_POSX_InBus};
  assign diffy     = {goaly_src[W-1], goaly_src} - {SC_GOAL_TRACKER_POSY_InBus[W-1], SC_GOAL_TRACKER_POSY_InBus};
  assign in_tol    = (mag(diffx) <= {1'b0, TOL}) && (mag(diffy) <= {1'b0, TOL});
  assign cnt_inc   = cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    goalx_d  = goalx_q;
    goaly_d  = goaly_q;
    errx_d   = errx_q;
    erry_d   = erry_q;
    cnt_d    = cnt_q;
    new_n_d  = 1'b1;
    flag_n_d = flag_n_q;
    if (!abort_n) begin
      state_d  = S_IDLE;
      errx_d   = '0;
      erry_d   = '0;
      cnt_d    = '0;
      flag_n_d = 1'b1;
    end else if (accept) begin
      // A sample coinciding with the accept updates errors but never counts toward settling.
      state_d  = S_TRACK;
      goalx_d  = SC_GOAL_TRACKER_GOALX_InBus;
      goaly_d  = SC_GOAL_TRACKER_GOALY_InBus;
      cnt_d    = '0;
      new_n_d  = 1'b0;
      flag_n_d = 1'b1;
      if (SC_GOAL_TRACKER_POS_VALID_In) begin
        errx_d = sat(diffx);
        erry_d = sat(diffy);
      end
    end else if (sample) begin
      errx_d = sat(diffx);
      erry_d = sat(diffy);
      case (state_q)
        S_TRACK: if (in_tol) begin
          cnt_d   = 8'd1;
          state_d = (SETTLE_N == 8'd1) ? S_REACHED : S_SETTLE;
          if (SETTLE_N == 8'd1) flag_n_d = 1'b0;
        end
        S_SETTLE: if (in_tol) begin
          cnt_d = cnt_inc;
          if (cnt_inc == SETTLE_N) begin
            state_d  = S_REACHED;
            flag_n_d = 1'b0;
          end
        end else begin
          state_d = S_TRACK;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      goalx_q  <= '0;
      goaly_q  <= '0;
      errx_q   <= '0;
      erry_q   <= '0;
      cnt_q    <= '0;
      new_n_q  <= 1'b1;
      flag_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      goalx_q  <= goalx_d;
      goaly_q  <= goaly_d;
      errx_q   <= errx_d;
      erry_q   <= erry_d;
      cnt_q    <= cnt_d;
      new_n_q  <= new_n_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign SC_GOAL_TRACKER_GOAL_READY_Out   = ready;
  assign SC_GOAL_TRACKER_ERRORX_OutBus    = errx_q;
  assign SC_GOAL_TRACKER_ERRORY_OutBus    = erry_q;
  assign SC_GOAL_TRACKER_NEWSIGNAL_OutLow = new_n_q;
  assign SC_GOAL_TRACKER_FLAGGOAL_OutLow  = flag_n_q;
  assign SC_GOAL_TRACKER_STATE_OutBus     = state_q;
endmodule

// File: tb/tb_sc_goal_tracker.sv
// Scoreboard bench for sc_goal_tracker: driver queues hand-computed expectations, monitor compares at negedge.
module tb_sc_goal_tracker;
`ifdef SC_GOAL_TRACKER_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, gvalid, pvalid, abort_n;
  logic [16:0] gx, gy, px, py;
  logic        ready, new_n, flag_n;
  logic [16:0] errx, erry;
  logic [1:0]  state;

  typedef struct {
    int          due;
    logic [38:0] v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  sc_goal_tracker dut (
    .SC_GOAL_TRACKER_CLOCK_50        (clk),
    .SC_GOAL_TRACKER_RESET_InHigh    (rst),
    .SC_GOAL_TRACKER_GOAL_VALID_In   (gvalid),
    .SC_GOAL_TRACKER_GOAL_READY_Out  (ready),
    .SC_GOAL_TRACKER_GOALX_InBus     (gx),
    .SC_GOAL_TRACKER_GOALY_InBus     (gy),
    .SC_GOAL_TRACKER_POS_VALID_In    (pvalid),
    .SC_GOAL_TRACKER_POSX_InBus      (px),
    .SC_GOAL_TRACKER_POSY_InBus      (py),
    .SC_GOAL_TRACKER_ABORT_InLow     (abort_n),
    .SC_GOAL_TRACKER_ERRORX_OutBus   (errx),
    .SC_GOAL_TRACKER_ERRORY_OutBus   (erry),
    .SC_GOAL_TRACKER_NEWSIGNAL_OutLow(new_n),
    .SC_GOAL_TRACKER_FLAGGOAL_OutLow (flag_n),
    .SC_GOAL_TRACKER_STATE_OutBus    (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are valid every cycle; pop whatever is due and compare.
  always @(negedge clk) begin
    exp_t        e;
    string       nm;
    logic [38:0] got;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {state, ready, errx, erry, new_n, flag_n};
      checks++;
      if (e.due != cyc || got !== e.v) begin
        errors++;
        $display("FAIL %s cyc=%0d got st=%0d rdy=%b ex=%0d ey=%0d nw=%b fl=%b exp st=%0d rdy=%b ex=%0d ey=%0d nw=%b fl=%b",
                 nm, cyc, got[38:37], got[36], $signed(got[35:19]), $signed(got[18:2]), got[1], got[0],
                 e.v[38:37], e.v[36], $signed(e.v[35:19]), $signed(e.v[18:2]), e.v[1], e.v[0]);
      end
    end
  end

  task automatic step(input string nm, input bit r, input bit gv, input int gxi, input int gyi,
                      input bit pv, input int pxi, input int pyi, input bit ab,
                      input int est, input bit erdy, input int eex, input int eey,
                      input bit enw, input bit efl);
    exp_t e;
    logic [16:0] ex17, ey17;
    logic [1:0]  s2;
    rst = r; gvalid = gv; pvalid = pv; abort_n = ab;
    gx = gxi[16:0]; gy = gyi[16:0]; px = pxi[16:0]; py = pyi[16:0];
    ex17 = eex[16:0]; ey17 = eey[16:0]; s2 = est[1:0];
    e.due = cyc + 1;
    e.v   = {s2, erdy, ex17, ey17, enw, efl};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; gvalid = 1'b0; pvalid = 1'b0; abort_n = 1'b1;
    gx = '0; gy = '0; px = '0; py = '0;
    @(negedge clk);
    #1;
    step("reset",            1, 0,    0,    0, 0,    0,   0, 1, 0, 1,    0,    0, 1, 1);
    step("idle_pos_ignored", 0, 0,    0,    0, 1,    5,   5, 1, 0, 1,    0,    0, 1, 1);
    step("accept_with_pos",  0, 1,  100, -200, 1,    0,   0, 1, 1, PRE, 100, -200, 0, 1);
    step("track_hold",       0, 0,    0,    0, 0,    0,   0, 1, 1, PRE, 100, -200, 1, 1);
    step("offer_in_track",   0, 1,  100, -200, 0,    0,   0, 1, 1, PRE, 100, -200, !PRE, 1);
    for (int i = 0; i < 7; i++)
      step("settle_run7",    0, 0,    0,    0, 1,   90, -180, 1, 2, PRE, 10, -20, 1, 1);
    step("out_of_tol",       0, 0,    0,    0, 1,    0,   0, 1, 1, PRE, 100, -200, 1, 1);
    for (int i = 0; i < 7; i++)
      step("settle_run8",    0, 0,    0,    0, 1,   90, -180, 1, 2, PRE, 10, -20, 1, 1);
    step("arrive",           0, 0,    0,    0, 1,   90, -180, 1, 3, 1,   10,  -20, 1, 0);
    step("reached_leave",    0, 0,    0,    0, 1,    0,   0, 1, 3, 1,   100, -200, 1, 0);
    step("accept_reached",   0, 1, 65535,   0, 0,    0,   0, 1, 1, PRE, 100, -200, 0, 1);
    step("sat_pos",          0, 0,    0,    0, 1, -65536, 0, 1, 1, PRE, 65535,  0, 1, 1);
    step("enter_settle",     0, 0,    0,    0, 1, 65500, 10, 1, 2, PRE, 35,   -10, 1, 1);
    step("abort_with_goal",  0, 1,    5,    5, 1,    0,   0, 0, 0, 0,    0,    0, 1, 1);
    step("abort_release",    0, 0,    0,    0, 0,    0,   0, 1, 0, 1,    0,    0, 1, 1);
    step("accept_neg_sat",   0, 1, -65536,  0, 1, 65535,  0, 1, 1, PRE, -65536, 0, 0, 1);
    step("abort2",           0, 0,    0,    0, 0,    0,   0, 0, 0, 0,    0,    0, 1, 1);
    step("release2",         0, 0,    0,    0, 0,    0,   0, 1, 0, 1,    0,    0, 1, 1);
    step("accept_pre_rst",   0, 1, -300,  400, 1,  100, 100, 1, 1, PRE, -400, 300, 0, 1);
    step("reset_cuts_pulse", 1, 0,    0,    0, 0,    0,   0, 1, 0, 1,    0,    0, 1, 1);
    step("after_reset",      0, 0,    0,    0, 0,    0,   0, 1, 0, 1,    0,    0, 1, 1);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
